// File: rtl/ysyx_axi4_sram_if.sv
// ysyx_axi4_sram_if -- AXI4 bus bundle between a master and the SRAM slave.
//
// Signals: AR channel (arid, araddr, arlen, arsize, arburst, arvalid/arready),
//          R channel  (rid, rdata, rresp, rlast, rvalid/rready),
//          AW channel (awid, awaddr, awlen, awsize, awburst, awvalid/awready),
//          W channel  (wdata, wstrb, wlast, wvalid/wready),
//          B channel  (bid, bresp, bvalid/bready).
// Modports: master drives requests and the ready signals of R/B;
//           slave drives the responses and the ready signals of AR/AW/W.
interface ysyx_axi4_sram_if #(
    parameter int XLEN = 32
);
    logic [3:0]      arid;
    logic [XLEN-1:0] araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [3:0]      rid;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [3:0]      awid;
    logic [XLEN-1:0] awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [3:0]      bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/ysyx_axi4_sram.sv
// ysyx_axi4_sram -- AXI4 slave backed by a DEPTH x XLEN word memory.
//
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   bus           : ysyx_axi4_sram_if.slave (AR/R/AW/W/B channels)
//   dbg_r_state   : current read FSM state (R_IDLE=0, R_WAIT=1, R_DATA=2)
//   dbg_w_state   : current write FSM state (W_COLLECT=0, W_RESP=1)
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1; a source holds its payload stable while
// valid=1 and ready=0, and valid never waits on ready.
//
// Reads: one burst at a time; first beat RLAT cycles after the AR transfer,
// then one beat per accepted rready with no bubbles. Writes: single-beat only;
// AW and W are collected independently and committed together.
module ysyx_axi4_sram #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] BASE  = 'h8000_0000,
    parameter int              DEPTH = 1024,
    parameter int              RLAT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_axi4_sram_if.slave       bus,
    output logic [1:0]            dbg_r_state,
    output logic                  dbg_w_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN:0] LIMIT = {1'b0, BASE} + {1'b0, XLEN'(4 * DEPTH)};
    localparam logic [3:0] RLAT_M1 = 4'(RLAT - 1);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_t;

    logic [XLEN-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [XLEN-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    // ---------------- read path ----------------
    r_state_t        r_state, r_next;
    logic [3:0]      r_id;
    logic [XLEN-1:0] r_addr;
    logic [7:0]      r_len;
    logic [1:0]      r_burst;
    logic [7:0]      r_beat;
    logic [3:0]      r_cnt;
    logic            ar_hs, r_last, r_err, r_out;

    assign ar_hs  = bus.arvalid && (r_state == R_IDLE);
    assign r_last = (r_beat == r_len);
    // Range is judged per beat so an INCR burst running off the end errors
    // only on the beats that are actually outside the memory.
    assign r_err  = r_burst[1] || !in_range(r_addr);
    assign r_out  = !reset && (r_state == R_DATA);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.arvalid) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) r_next = R_DATA;
            R_DATA:  if (bus.rready && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= bus.arid;
                r_addr  <= {bus.araddr[XLEN-1:2], 2'b00};
                r_len   <= bus.arlen;
                r_burst <= bus.arburst;
                r_beat  <= '0;
                r_cnt   <= RLAT_M1;
            end
            if (r_state == R_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_state == R_DATA && bus.rready && !r_last) begin
                r_beat <= r_beat + 8'd1;
                if (r_burst == 2'b01) r_addr <= r_addr + XLEN'(4);
            end
        end
    end

    // Responses are combinational from registers that only move on a beat
    // transfer, so they hold while stalled. The data path reads the memory
    // live, so a write committed to the very word of a stalled beat shows up.
    assign bus.arready = reset || (r_state == R_IDLE);
    assign bus.rvalid  = r_out;
    assign bus.rid     = r_out ? r_id : 4'd0;
    assign bus.rlast   = r_out && r_last;
    assign bus.rresp   = (r_out && r_err) ? 2'b10 : 2'b00;
    assign bus.rdata   = (r_out && !r_err) ? mem[word_idx(r_addr)] : '0;

    // ---------------- write path ----------------
    w_state_t        w_state, w_next;
    logic            aw_held, w_held;
    logic [3:0]      aw_id;
    logic [XLEN-1:0] aw_addr;
    logic [7:0]      aw_len;
    logic [XLEN-1:0] w_data;
    logic [3:0]      w_strb;
    logic            w_last;
    logic [3:0]      b_id;
    logic [1:0]      b_resp;
    logic            aw_hs, w_hs, commit, c_err;
    logic [3:0]      c_id;
    logic [XLEN-1:0] c_addr, c_data;
    logic [7:0]      c_len;
    logic [3:0]      c_strb;
    logic            c_last;

    assign aw_hs = bus.awvalid && (w_state == W_COLLECT) && !aw_held;
    assign w_hs  = bus.wvalid && (w_state == W_COLLECT) && !w_held;

    // A channel arriving in the commit cycle is used straight off the bus.
    assign c_id   = aw_held ? aw_id   : bus.awid;
    assign c_addr = aw_held ? aw_addr : bus.awaddr;
    assign c_len  = aw_held ? aw_len  : bus.awlen;
    assign c_data = w_held  ? w_data  : bus.wdata;
    assign c_strb = w_held  ? w_strb  : bus.wstrb;
    assign c_last = w_held  ? w_last  : bus.wlast;

    assign commit = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);
    assign c_err  = (c_len != 8'd0) || !in_range(c_addr) || !c_last;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_COLLECT: if (commit) w_next = W_RESP;
            W_RESP:    if (bus.bready) w_next = W_COLLECT;
            default:   w_next = W_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_id   <= '0;
            aw_addr <= '0;
            aw_len  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_last  <= 1'b0;
            b_id    <= '0;
            b_resp  <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_id   <= bus.awid;
                aw_addr <= bus.awaddr;
                aw_len  <= bus.awlen;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
                w_last <= bus.wlast;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_id    <= c_id;
                b_resp  <= c_err ? 2'b10 : 2'b00;
            end
        end
    end

    // Memory has no reset: contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (!reset && commit && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) mem[word_idx(c_addr)][i*8 +: 8] <= c_data[i*8 +: 8];
            end
        end
    end

    assign bus.awready = reset || ((w_state == W_COLLECT) && !aw_held);
    assign bus.wready  = reset || ((w_state == W_COLLECT) && !w_held);
    assign bus.bvalid  = !reset && (w_state == W_RESP);
    assign bus.bid     = bus.bvalid ? b_id : 4'd0;
    assign bus.bresp   = bus.bvalid ? b_resp : 2'b00;

    assign dbg_r_state = r_state;
    assign dbg_w_state = w_state;

    // Size and burst-type fields on writes, and the byte offset of read
    // addresses, do not affect addressing.
    logic unused_bits;
    assign unused_bits = ^{bus.arsize, bus.awsize, bus.awburst, bus.araddr[1:0]};
endmodule

// File: tb/tb_ysyx_axi4_sram.sv
// tb_ysyx_axi4_sram -- directed plus randomized bench for ysyx_axi4_sram.
// A word-indexed reference memory predicts every read beat and write response.
module tb_ysyx_axi4_sram;
    localparam int          XLEN  = 32;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          RLAT  = 2;
    localparam logic [63:0] LIMIT = 64'(BASE) + 64'(4 * DEPTH);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_r_state;
    logic       dbg_w_state;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    logic [31:0] ref_mem [int];
    int          stamps[$];
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    ysyx_axi4_sram_if #(.XLEN(XLEN)) bus ();

    ysyx_axi4_sram #(
        .XLEN(XLEN), .BASE(BASE), .DEPTH(DEPTH), .RLAT(RLAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .dbg_r_state(dbg_r_state),
        .dbg_w_state(dbg_w_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < LIMIT);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // ---------------- drivers ----------------
    // mode 0: AW and W together; 1: W one cycle before AW; 2: AW one cycle before W.
    // Called and returns on a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [7:0] len,
                            input bit last, input logic [3:0] id, input int mode);
        bit aw_done, w_done, aw_f, w_f, err;
        int t, guard, w;
        logic [1:0]  exp_resp;
        logic [31:0] cur;
        aw_done = 0; w_done = 0; t = 0;
        err = (len != 8'd0) || !in_rng(addr) || !last;
        exp_resp = err ? 2'b10 : 2'b00;
        while (!(aw_done && w_done) && t < 40) begin
            if (!w_done && t >= ((mode == 2) ? 1 : 0)) begin
                bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
            end
            if (!aw_done && t >= ((mode == 1) ? 1 : 0)) begin
                bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awid = id;
                bus.awsize = 3'd2; bus.awburst = 2'b01;
            end
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge clock);
            if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  bus.wvalid = 1'b0;  end
            if (aw_done && !w_done) check("awready_while_held", 64'(bus.awready), 0);
            if (w_done && !aw_done) check("wready_while_held", 64'(bus.wready), 0);
            t++;
        end
        check("write_handshake_timeout", 64'(aw_done && w_done), 1);
        bus.bready = 1'b1;
        guard = 0;
        while (!bus.bvalid && guard < 20) begin @(negedge clock); guard++; end
        check("bvalid_timeout", 64'(bus.bvalid), 1);
        check("bresp", 64'(bus.bresp), 64'(exp_resp));
        check("bid", 64'(bus.bid), 64'(id));
        @(negedge clock);
        bus.bready = 1'b0;
        if (!err) begin
            w = widx(addr);
            cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            for (int i = 0; i < 4; i++) if (strb[i]) cur[i*8 +: 8] = data[i*8 +: 8];
            ref_mem[w] = cur;
        end
    endtask

    // rr_mode 0: rready always 1; 1: toggles 1,0,1,0 per valid beat; 2: random.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id, input int rr_mode);
        int hs, beat, guard, k;
        bit lat_done, err;
        logic [31:0] a;
        stamps.delete();
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arid = id; bus.arsize = 3'd2;
        guard = 0;
        while (!bus.arready && guard < 40) begin @(negedge clock); guard++; end
        check("arready_timeout", 64'(bus.arready), 1);
        @(negedge clock);
        bus.arvalid = 1'b0;
        hs = cyc_cnt;
        beat = 0; guard = 0; k = 0; lat_done = 0;
        while (beat <= int'(len) && guard < 300) begin
            case (rr_mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = (k % 2 == 0);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            if (bus.rvalid) begin
                if (!lat_done) begin
                    check("first_rvalid_latency", 64'(cyc_cnt - hs), 64'(RLAT));
                    lat_done = 1;
                end
                a = {addr[31:2], 2'b00} + ((burst == 2'b01) ? 32'(4 * beat) : 32'd0);
                err = burst[1] || !in_rng(a);
                check("rresp", 64'(bus.rresp), err ? 64'd2 : 64'd0);
                check("rid", 64'(bus.rid), 64'(id));
                check("rlast", 64'(bus.rlast), 64'(beat == int'(len)));
                if (err) check("rdata_on_error", 64'(bus.rdata), 0);
                else if (ref_mem.exists(widx(a))) check("rdata", 64'(bus.rdata), 64'(ref_mem[widx(a)]));
                last_rdata = bus.rdata;
                last_rresp = bus.rresp;
                if (bus.rready) begin beat++; stamps.push_back(cyc_cnt); end
                k++;
            end
            @(negedge clock);
            guard++;
        end
        bus.rready = 1'b0;
        check("read_beats", 64'(beat), 64'(int'(len) + 1));
        check("rvalid_after_last", 64'(bus.rvalid), 0);
        check("arready_after_last", 64'(bus.arready), 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int beats, guard, w, sel;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arvalid = 0;
        bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0;
        bus.bready = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);

        check("reset_arready", 64'(bus.arready), 1);
        check("reset_awready", 64'(bus.awready), 1);
        check("reset_wready", 64'(bus.wready), 1);
        check("reset_rvalid", 64'(bus.rvalid), 0);
        check("reset_rlast", 64'(bus.rlast), 0);
        check("reset_bvalid", 64'(bus.bvalid), 0);
        check("reset_rresp", 64'(bus.rresp), 0);
        check("reset_bresp", 64'(bus.bresp), 0);
        check("reset_rid", 64'(bus.rid), 0);
        check("reset_bid", 64'(bus.bid), 0);
        check("reset_rdata", 64'(bus.rdata), 0);
        check("reset_r_state", 64'(dbg_r_state), 0);
        check("reset_w_state", 64'(dbg_w_state), 0);
        reset = 1'b0;
        @(negedge clock);

        // Fill the first 64 words with known random data.
        for (int i = 0; i < 64; i++)
            do_write(BASE + 32'(4 * i), $urandom, 4'hF, 8'd0, 1'b1, 4'(i), $urandom_range(0, 2));

        // W leads AW, then read back with latency check.
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 8'd0, 1'b1, 4'd3, 1);
        do_read(32'h8000_0010, 8'd0, 2'b01, 4'd2, 0);
        check("deadbeef_readback", 64'(last_rdata), 64'h0000_0000_DEADBEEF);

        // INCR burst of four with rready toggling.
        do_read(BASE, 8'd3, 2'b01, 4'd5, 1);

        // Byte-strobe merge.
        do_write(32'h8000_0020, 32'h11223344, 4'hF, 8'd0, 1'b1, 4'd1, 0);
        do_write(32'h8000_0020, 32'hAABBCCDD, 4'h6, 8'd0, 1'b1, 4'd2, 2);
        do_read(32'h8000_0020, 8'd0, 2'b01, 4'd6, 0);
        check("strobe_merge", 64'(last_rdata), 64'h0000_0000_11BBCC44);

        // Error cases: read past the end, bursts, bad writes.
        do_read(BASE + 32'(4 * DEPTH), 8'd1, 2'b01, 4'd1, 0);
        check("oob_read_resp", 64'(last_rresp), 2);
        do_write(BASE + 32'h30, 32'h5555_AAAA, 4'hF, 8'd2, 1'b1, 4'd7, 0);
        do_write(BASE + 32'h34, 32'h1234_5678, 4'hF, 8'd0, 1'b0, 4'd8, 1);
        do_write(BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD, 4'hF, 8'd0, 1'b1, 4'd9, 2);
        do_read(BASE + 32'h30, 8'd1, 2'b01, 4'd3, 2);
        do_read(BASE + 32'h08, 8'd3, 2'b00, 4'd4, 2);
        do_read(BASE + 32'h08, 8'd2, 2'b10, 4'd4, 0);
        do_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 2'b01, 4'd10, 0);

        // Concurrent write during an 8-beat read: beats stay back to back.
        fork
            do_read(BASE, 8'd7, 2'b01, 4'd7, 0);
            begin
                repeat (4) @(negedge clock);
                do_write(BASE + 32'(4 * 40), $urandom, 4'hF, 8'd0, 1'b1, 4'd9, 0);
            end
        join
        for (int i = 1; i < stamps.size(); i++)
            check("zero_bubble_beats", 64'(stamps[i] - stamps[i-1]), 1);

        // Reset during the third beat of an 8-beat burst.
        bus.arvalid = 1'b1; bus.araddr = BASE; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arid = 4'd4;
        guard = 0;
        while (!bus.arready && guard < 40) begin @(negedge clock); guard++; end
        @(negedge clock);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        beats = 0; guard = 0;
        while (beats < 2 && guard < 50) begin
            if (bus.rvalid) beats++;
            @(negedge clock);
            guard++;
        end
        check("third_beat_valid", 64'(bus.rvalid), 1);
        reset = 1'b1;
        @(negedge clock);
        check("rvalid_after_reset", 64'(bus.rvalid), 0);
        check("arready_after_reset", 64'(bus.arready), 1);
        check("r_state_after_reset", 64'(dbg_r_state), 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("no_beats_after_reset", 64'(bus.rvalid), 0);
        end
        bus.rready = 1'b0;
        do_read(BASE, 8'd7, 2'b01, 4'd11, 2);

        // Randomized mix of writes and reads against the reference memory.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom_range(0, 63);
                sel = $urandom_range(0, 9);
                do_write(BASE + 32'(4 * w), $urandom, 4'($urandom_range(0, 15)),
                         (sel == 0) ? 8'd1 : 8'd0, (sel != 1), 4'($urandom), $urandom_range(0, 2));
            end else begin
                w = $urandom_range(0, 56);
                do_read(BASE + 32'(4 * w) + 32'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
                        ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01, 4'($urandom), 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_axi4_sram.md
YSYX_AXI4_SRAM -- requirements
Module: ysyx_axi4_sram

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-003 SHALL have parameter DEPTH, default 1024: number of XLEN-bit words.
REQ-004 SHALL have parameter RLAT, default 2: cycles from AR handshake to first rvalid, range 1..15.
REQ-005 SHALL have ports: clock in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: arid in 4; araddr in XLEN; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
REQ-007 SHALL have ports: rid out 4; rdata out XLEN; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
REQ-008 SHALL have ports: awid in 4; awaddr in XLEN; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-009 SHALL have ports: wdata in XLEN; wstrb in 4; wlast in 1; wvalid in 1; wready out 1.
REQ-010 SHALL have ports: bid out 4; bresp out 2; bvalid out 1; bready in 1.

Function
REQ-011 The read FSM SHALL have states R_IDLE, R_WAIT and R_DATA; arready=1 only in R_IDLE.
REQ-012 On arvalid&&arready the block SHALL latch arid, word-aligned araddr, arlen and arburst, clear the beat counter, load the latency counter with RLAT-1, and enter R_WAIT.
REQ-013 R_WAIT SHALL decrement the counter each cycle and enter R_DATA on the cycle the counter is 0, so first rvalid rises exactly RLAT cycles after the AR handshake.
REQ-014 In R_DATA: rvalid=1; rid=latched id; rdata=mem[(addr-BASE)>>2]; rlast=1 iff beat counter == latched arlen.
REQ-015 rdata, rresp, rlast and rid SHALL be held stable while rvalid&&!rready.
REQ-016 On rvalid&&rready with !rlast, the beat counter SHALL increment; addr SHALL add 4 for INCR (2'b01) and hold for FIXED (2'b00); rvalid stays 1 the next cycle with zero bubble.
REQ-017 On rvalid&&rready&&rlast the FSM SHALL return to R_IDLE; a new AR SHALL be accepted no earlier than the following cycle.
REQ-018 An address outside [BASE, BASE+4*DEPTH) or burst type 2'b1x SHALL give rresp=2'b10 (SLVERR) with rdata=0; the beat count still follows arlen; otherwise rresp=2'b00.
REQ-019 The write FSM SHALL have states W_COLLECT and W_RESP; AW and W are captured independently in either order or in the same cycle.
REQ-020 In W_COLLECT, awready SHALL be high while no AW is held and wready SHALL be high while no W is held; each handshake latches its fields and sets its held flag.
REQ-021 When both flags are set, or are set by same-cycle handshakes, the block SHALL, in that cycle's clock edge, write byte lane i of mem only where wstrb[i]=1, clear both flags, and enter W_RESP.
REQ-022 In W_RESP: bvalid=1, bid=latched awid, awready=wready=0; on bvalid&&bready the FSM returns to W_COLLECT.
REQ-023 awlen!=0, out-of-range awaddr, or wlast=0 SHALL give bresp=2'b10 and leave memory unmodified; otherwise bresp=2'b00.
REQ-024 The read and write paths SHALL run concurrently; a read beat presented on or after the cycle after a write commit SHALL return the written data.
REQ-025 arsize and awsize SHALL be ignored for addressing; wstrb alone selects the written bytes.

Reset
REQ-026 While reset=1, all FSMs SHALL enter idle; arready=1, awready=1, wready=1; rvalid, rlast, bvalid, rresp, bresp, rid, bid and rdata = 0; both held flags clear.
REQ-027 Reset mid-burst or mid-response SHALL abandon the transaction with no further beats.
REQ-028 Memory contents SHALL NOT be altered by reset.

Verification
REQ-029 Write 0x8000_0010 = 0xDEADBEEF with wstrb=0xF, W one cycle before AW -> bvalid with bresp=0; then read with RLAT=2 -> rvalid rises 2 cycles after the AR handshake with rdata=0xDEADBEEF, rlast=1.
REQ-030 INCR read at 0x8000_0000, arlen=3, arid=5, rready toggling 1,0,1,0... -> four beats of words 0..3, rid=5, data stable while stalled, rlast on beat 4 only.
REQ-031 Word 0x8000_0020=0x11223344, then write wdata=0xAABBCCDD with wstrb=0x6 -> readback returns 0x11BBCC44.
REQ-032 Read araddr=BASE+4*DEPTH with arlen=1 -> two beats, rresp=2'b10, rdata=0; write awlen=2 -> bresp=2'b10 and memory unchanged.
REQ-033 Same-cycle AW+W while an INCR read with arlen=7 streams -> write completes without stalling the read beats; assert reset during the 3rd read beat -> rvalid=0 the next cycle, arready=1.
